// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB bus between N requesters; runs SETUP/ACCESS itself.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles (ERR=1).
module apb_rr_arbiter #(
    parameter int unsigned N              = 2,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic [N-1:0]    REQ,
    input  logic [N-1:0]    REQ_WRITE,
    input  logic [N*AW-1:0] REQ_ADDR,
    input  logic [N*DW-1:0] REQ_WDATA,
    output logic [N-1:0]    GNT,
    output logic [N-1:0]    DONE,
    output logic [DW-1:0]   RDATA,
    output logic            ERR,
    output logic            PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [AW-1:0]   PADDR,
    output logic [DW-1:0]   PWDATA,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic            win_write;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [N-1:0]    elig;
    logic            timeout;

    // A requester is masked in its own DONE cycle so a held REQ is not re-granted at once.
    always_comb begin
        elig      = REQ & ~DONE;
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (win_idx == IW'(k)) begin
                win_write = REQ_WRITE[k];
                win_addr  = REQ_ADDR[k*AW +: AW];
                win_wdata = REQ_WDATA[k*DW +: DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the stalled cycle whose increment would reach TIMEOUT_CYCLES.
    always_comb begin
        timeout = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                PSEL     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ptr    <= IW'(N - 1);
            GNT    <= '0;
            DONE   <= '0;
            RDATA  <= '0;
            ERR    <= 1'b0;
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else begin
            DONE <= '0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        ptr    <= win_idx;
                        GNT    <= N'(1) << win_idx;
                        PWRITE <= win_write;
                        PADDR  <= win_addr;
                        PWDATA <= win_wdata;
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        GNT  <= '0;
                        DONE <= GNT;
                        if (!PWRITE) begin
                            RDATA <= PRDATA;
                        end
                    end else if (timeout) begin
                        GNT   <= '0;
                        DONE  <= GNT;
                        ERR   <= 1'b1;
                        RDATA <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
